// File: rtl/rast_pkg.sv
// Shared rasterizer types, sub-sample rate encodings and step helper.
package rast_pkg;

    localparam int unsigned SIGFIG = 24;  // bits in color and position
    localparam int unsigned RADIX  = 10;  // fraction bits in position
    localparam int unsigned VERTS  = 3;
    localparam int unsigned AXIS   = 3;
    localparam int unsigned COLORS = 3;

    typedef enum logic {WAIT, TEST} samp_state_t;

    // One-hot sub-sample rates
    localparam logic [3:0] SS_1X  = 4'b1000;
    localparam logic [3:0] SS_4X  = 4'b0100;
    localparam logic [3:0] SS_16X = 4'b0010;
    localparam logic [3:0] SS_64X = 4'b0001;

    // Grid step for a rate; anything unrecognised walks at 1x
    function automatic logic [SIGFIG-1:0] ss_step(input logic [3:0]  sub_sample,
                                                  input int unsigned radix);
        logic [SIGFIG-1:0] one;
        logic [SIGFIG-1:0] step;
        one = SIGFIG'(1);
        case (sub_sample)
            SS_4X:   step = one << (radix - 1);
            SS_16X:  step = one << (radix - 2);
            SS_64X:  step = one << (radix - 3);
            default: step = one << radix;
        endcase
        return step;
    endfunction

endpackage

// File: rtl/samp_step_dec.sv
// Combinational sub-sample rate decoder: one-hot rate in, grid step out.
module samp_step_dec
    import rast_pkg::*;
(
    input  logic [3:0]        sub_sample_i,
    output logic [SIGFIG-1:0] step_o,
    output logic              invalid_o
);

    // Non-one-hot rates are flagged and fall back to the 1x step
    always_comb begin
        invalid_o = !$onehot(sub_sample_i);
        step_o    = ss_step(invalid_o ? SS_1X : sub_sample_i, RADIX);
    end

endmodule

// File: rtl/sample_iterator.sv
// Bounding-box sample scheduler: latches one triangle and walks its box row-major,
// one sample per cycle, stalling upstream while the walk is in progress.
module sample_iterator
    import rast_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic [3:0]               subSample_RnnnnU,
    input  logic                     halt_RnnnnH,
    output logic                     halt_R13H,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H
);

    samp_state_t state_q, state_d;

    logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
    logic signed [SIGFIG-1:0] tri_d [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_q [COLORS];
    logic        [SIGFIG-1:0] color_d [COLORS];

    logic signed [SIGFIG-1:0] x_q, x_d, y_q, y_d;
    logic signed [SIGFIG-1:0] llx_q, llx_d, urx_q, urx_d, ury_q, ury_d;
    logic        [SIGFIG-1:0] step_q, step_d;

    logic [SIGFIG-1:0] step_dec;
    logic              unused_ss_invalid;

    // One extra bit so stepping past the top of the range cannot wrap negative
    logic signed [SIGFIG:0] nx, ny, urx_ext, ury_ext;

    samp_step_dec u_step_dec (
        .sub_sample_i (subSample_RnnnnU),
        .step_o       (step_dec),
        .invalid_o    (unused_ss_invalid)
    );

    assign nx      = {x_q[SIGFIG-1], x_q} + {1'b0, step_q};
    assign ny      = {y_q[SIGFIG-1], y_q} + {1'b0, step_q};
    assign urx_ext = {urx_q[SIGFIG-1], urx_q};
    assign ury_ext = {ury_q[SIGFIG-1], ury_q};

    assign halt_R13H      = (state_q == TEST);
    assign validSamp_R14H = (state_q == TEST);
    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S[0] = x_q;
    assign sample_R14S[1] = y_q;

    // Next-state: accept in WAIT, advance the sample row-major in TEST
    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        color_d = color_q;
        x_d     = x_q;
        y_d     = y_q;
        llx_d   = llx_q;
        urx_d   = urx_q;
        ury_d   = ury_q;
        step_d  = step_q;

        unique case (state_q)
            WAIT: begin
                if (validTri_R13H) begin
                    tri_d   = tri_R13S;
                    color_d = color_R13U;
                    llx_d   = box_R13S[0][0];
                    urx_d   = box_R13S[1][0];
                    ury_d   = box_R13S[1][1];
                    step_d  = step_dec;
                    x_d     = box_R13S[0][0];
                    y_d     = box_R13S[0][1];
                    // Inverted boxes are dropped without emitting anything
                    if (box_R13S[0][0] <= box_R13S[1][0] && box_R13S[0][1] <= box_R13S[1][1]) begin
                        state_d = TEST;
                    end
                end
            end
            TEST: begin
                if (nx <= urx_ext) begin
                    x_d = nx[SIGFIG-1:0];
                end else if (ny <= ury_ext) begin
                    x_d = llx_q;
                    y_d = ny[SIGFIG-1:0];
                end else begin
                    state_d = WAIT;
                end
            end
            default: state_d = WAIT;
        endcase
    end

    // State registers; a downstream halt freezes everything
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WAIT;
            tri_q   <= '{default: '{default: '0}};
            color_q <= '{default: '0};
            x_q     <= '0;
            y_q     <= '0;
            llx_q   <= '0;
            urx_q   <= '0;
            ury_q   <= '0;
            step_q  <= '0;
        end else if (!halt_RnnnnH) begin
            state_q <= state_d;
            tri_q   <= tri_d;
            color_q <= color_d;
            x_q     <= x_d;
            y_q     <= y_d;
            llx_q   <= llx_d;
            urx_q   <= urx_d;
            ury_q   <= ury_d;
            step_q  <= step_d;
        end
    end

endmodule

// File: tb/tb_sample_iterator.sv
// Scoreboard bench for sample_iterator: a box-walk model fills a queue at accept time,
// a monitor pops one entry per consumed sample.
module tb_sample_iterator;
    import rast_pkg::*;

    localparam int TRI_W = VERTS * AXIS * SIGFIG;
    localparam int COL_W = COLORS * SIGFIG;

    typedef struct packed {
        logic signed [SIGFIG-1:0] x;
        logic signed [SIGFIG-1:0] y;
        logic [TRI_W-1:0]         tri_p;
        logic [COL_W-1:0]         col_p;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic signed [SIGFIG-1:0] tri_in [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_in [COLORS];
    logic signed [SIGFIG-1:0] box_in [2][2];
    logic                     valid_tri = 1'b0;
    logic [3:0]               sub_sample = 4'b1000;
    logic                     halt_dn = 1'b0;
    logic                     halt_up;
    logic signed [SIGFIG-1:0] tri_out [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_out [COLORS];
    logic signed [SIGFIG-1:0] sample_out [2];
    logic                     valid_samp;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    sample_iterator dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (color_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_tri),
        .subSample_RnnnnU (sub_sample),
        .halt_RnnnnH      (halt_dn),
        .halt_R13H        (halt_up),
        .tri_R14S         (tri_out),
        .color_R14U       (color_out),
        .sample_R14S      (sample_out),
        .validSamp_R14H   (valid_samp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [TRI_W-1:0] pack_tri_in();
        logic [TRI_W-1:0] p;
        p = '0;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) p[(v*AXIS+a)*SIGFIG +: SIGFIG] = tri_in[v][a];
        return p;
    endfunction

    function automatic logic [TRI_W-1:0] pack_tri_out();
        logic [TRI_W-1:0] p;
        p = '0;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) p[(v*AXIS+a)*SIGFIG +: SIGFIG] = tri_out[v][a];
        return p;
    endfunction

    function automatic logic [COL_W-1:0] pack_col_in();
        logic [COL_W-1:0] p;
        p = '0;
        for (int c = 0; c < COLORS; c++) p[c*SIGFIG +: SIGFIG] = color_in[c];
        return p;
    endfunction

    function automatic logic [COL_W-1:0] pack_col_out();
        logic [COL_W-1:0] p;
        p = '0;
        for (int c = 0; c < COLORS; c++) p[c*SIGFIG +: SIGFIG] = color_out[c];
        return p;
    endfunction

    function automatic int step_of(input logic [3:0] ss);
        case (ss)
            4'b0100: return 1 << (RADIX - 1);
            4'b0010: return 1 << (RADIX - 2);
            4'b0001: return 1 << (RADIX - 3);
            default: return 1 << RADIX;
        endcase
    endfunction

    // mode 0: never halt; 1: random halts; 2: halt cycles 2..4 of the walk (3rd sample)
    function automatic logic halt_for(input int mode, input int k);
        if (mode == 1) return (k < 300) && ($urandom_range(0, 3) == 0);
        if (mode == 2) return (k >= 2) && (k <= 4);
        return 1'b0;
    endfunction

    task automatic scramble_inputs();
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++) tri_in[v][a] = SIGFIG'($urandom);
        for (int c = 0; c < COLORS; c++) color_in[c] = SIGFIG'($urandom);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) box_in[i][j] = SIGFIG'($urandom);
        sub_sample = 4'($urandom);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 after the accept edge
    task automatic accept_tri(input int llx, input int lly, input int urx, input int ury,
                              input logic [3:0] ss, input int mode, output int n);
        exp_t e;
        int   step;
        int   tries;
        scramble_inputs();
        box_in[0][0] = SIGFIG'(llx);
        box_in[0][1] = SIGFIG'(lly);
        box_in[1][0] = SIGFIG'(urx);
        box_in[1][1] = SIGFIG'(ury);
        sub_sample = ss;
        valid_tri  = 1'b1;
        halt_dn    = halt_for(mode, -1);
        tries      = 0;
        forever begin
            @(negedge clk); #1;
            check("ready_up", 256'(halt_up), 256'(0));
            if (!halt_dn) break;
            @(posedge clk); #1;
            tries++;
            halt_dn = (tries < 50) ? halt_for(mode, -1) : 1'b0;
        end
        // Reference walk: every grid point of the box, rows bottom to top
        step    = step_of(ss);
        e.tri_p = pack_tri_in();
        e.col_p = pack_col_in();
        n       = 0;
        if (llx <= urx && lly <= ury) begin
            for (longint yy = lly; yy <= ury; yy += step) begin
                for (longint xx = llx; xx <= urx; xx += step) begin
                    e.x = SIGFIG'(xx);
                    e.y = SIGFIG'(yy);
                    exp_q.push_back(e);
                    n++;
                end
            end
        end
        @(posedge clk); #1;
        valid_tri = 1'b0;
        scramble_inputs();  // latched copies must not follow the inputs
        halt_dn = halt_for(mode, 0);
    endtask

    task automatic drain(input int n, input int mode);
        int rem;
        int k;
        rem = n;
        k   = 0;
        forever begin
            @(negedge clk); #1;
            check("valid_samp", 256'(valid_samp), 256'(rem > 0));
            check("halt_up_busy", 256'(halt_up), 256'(rem > 0));
            if (rem == 0) break;
            if (!halt_dn) rem--;
            @(posedge clk); #1;
            k++;
            halt_dn = halt_for(mode, k);
        end
        halt_dn = 1'b0;
        check("queue_drained", 256'(exp_q.size()), 256'(0));
        @(posedge clk); #1;
    endtask

    task automatic run_tri(input int llx, input int lly, input int urx, input int ury,
                           input logic [3:0] ss, input int mode);
        int n;
        accept_tri(llx, lly, urx, ury, ss, mode, n);
        drain(n, mode);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 256'(valid_samp), 256'(0));
        check({tag, "_halt_up"}, 256'(halt_up), 256'(0));
        check({tag, "_x"}, 256'(sample_out[0]), 256'(0));
        check({tag, "_y"}, 256'(sample_out[1]), 256'(0));
        check({tag, "_tri"}, 256'(pack_tri_out()), 256'(0));
        check({tag, "_color"}, 256'(pack_col_out()), 256'(0));
    endtask

    // Monitor: every sample presented without a downstream halt is consumed
    always @(negedge clk) begin
        exp_t e;
        if (rst && valid_samp && !halt_dn) begin
            if (exp_q.size() == 0) begin
                check("unexpected_sample", 256'(1), 256'(0));
            end else begin
                e = exp_q.pop_front();
                check("sample_x", 256'(sample_out[0]), 256'(e.x));
                check("sample_y", 256'(sample_out[1]), 256'(e.y));
                check("tri_held", 256'(pack_tri_out()), 256'(e.tri_p));
                check("color_held", 256'(pack_col_out()), 256'(e.col_p));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, got no end, expected end");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic [3:0] ss;
        int step, llx, lly, urx, ury;
        scramble_inputs();
        sub_sample = SS_1X;
        #2;
        check_all_zero("reset");
        #20 rst = 1'b1;
        @(posedge clk); #1;

        // 1x walk
        run_tri(0, 0, 2048, 1024, SS_1X, 0);
        // 4x walk
        run_tri(1024, 1024, 1536, 1536, SS_4X, 0);
        // 3rd sample held under a 3-cycle downstream halt
        run_tri(0, 0, 2048, 1024, SS_1X, 2);
        // Inverted box is dropped, next triangle still accepted
        run_tri(2048, 0, 1024, 0, SS_1X, 0);
        run_tri(0, 0, 2048, 1024, SS_1X, 0);

        // Asynchronous reset in the middle of a walk
        accept_tri(0, 0, 2048, 1024, SS_1X, 0, n);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("midwalk_reset");
        exp_q.delete();
        @(posedge clk); #1;
        check_all_zero("held_reset");
        #3 rst = 1'b1;
        @(posedge clk); #1;
        run_tri(1024, 2048, 2048, 2048, SS_1X, 0);

        // Single point at 64x
        run_tri(3072, 3072, 3072, 3072, SS_64X, 0);
        // Right edge at the top of the signed range must not wrap
        run_tri(8386560, -1024, 8387584, 0, SS_1X, 0);
        // Negative corner at 16x
        run_tri(-512, -256, 0, 0, SS_16X, 0);

        // Random boxes, rates and halts
        for (int t = 0; t < 40; t++) begin
            ss   = 4'b1000 >> $urandom_range(0, 3);
            step = step_of(ss);
            llx  = (int'($urandom_range(0, 8)) - 4) * step;
            lly  = (int'($urandom_range(0, 8)) - 4) * step;
            urx  = llx + (int'($urandom_range(0, 5)) - 1) * step;
            ury  = lly + (int'($urandom_range(0, 5)) - 1) * step;
            run_tri(llx, lly, urx, ury, ss, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
